// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the load/store data memory.
// Size/state enums plus the lane-strobe and load-extension functions.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [3:0] gen_strobe(input size_e sz, input logic [1:0] off);
    logic [3:0] strb;
    strb = 4'b0000;
    case (sz)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << off;
      SZ_WORD: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Picks the addressed byte/half out of the full word, then extends it.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input size_e sz,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = word[{off, 3'b000} +: 8];
    h   = word[{off[1], 4'b0000} +: 16];
    res = 32'h0;
    case (sz)
      SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the load/store unit and the data memory.
interface data_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_lane.sv
// One 8-bit byte lane of the data memory: synchronous write, registered read.
// Kept as its own module so it can be replaced by a hard SRAM macro.
module mem_lane #(
  parameter int DEPTH_W = 256,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with valid/ready requests, one-cycle responses,
// sign/zero-extended loads, alignment/range errors and a post-reset zero sweep.
module data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
`ifdef USE_POWER_PINS
  inout wire            vccd1,
  inout wire            vssd1,
`endif
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  localparam int DEPTH_W = 2 ** (ADDR_BITS - 2);
  localparam int IDX_W   = (ADDR_BITS > 2) ? ADDR_BITS - 2 : 1;

  state_e           state, next_state;
  logic [IDX_W-1:0] clr_cnt;
  logic             clearing;

  logic             accept;
  size_e            size;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic [3:0]       strobe;
  logic [31:0]      rep_data;

  logic [3:0]       lane_we;
  logic [IDX_W-1:0] lane_widx;
  logic [7:0]       lane_wdata [4];
  logic [7:0]       lane_rdata [4];
  logic             lane_re;
  logic [31:0]      lane_word;

  logic             rsp_load;
  size_e            rsp_size;
  logic [1:0]       rsp_off;
  logic             rsp_uns;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (state == ST_CLEAR && clr_cnt == IDX_W'(DEPTH_W - 1)) next_state = ST_READY;
  end

  always_comb begin
    bus.req_ready = (state == ST_READY);
    clearing      = (state == ST_CLEAR);
  end

  // Out-of-range upper address bits, reserved size and misalignment all error out.
  always_comb begin
    accept = bus.req_valid && bus.req_ready;
    size   = size_e'(bus.req_size);
    off    = bus.req_addr[1:0];
    idx    = IDX_W'(bus.req_addr >> 2);
    err    = ((bus.req_addr >> ADDR_BITS) != 32'h0) ||
             (size == SZ_RSVD) ||
             (size == SZ_HALF && off[0]) ||
             (size == SZ_WORD && off != 2'b00);
    strobe = gen_strobe(size, off);
    case (size)
      SZ_BYTE: rep_data = {4{bus.req_wdata[7:0]}};
      SZ_HALF: rep_data = {2{bus.req_wdata[15:0]}};
      default: rep_data = bus.req_wdata;
    endcase
  end

  always_comb begin
    lane_widx = clearing ? clr_cnt : idx;
    lane_re   = accept && !bus.req_we && !err;
    for (int k = 0; k < 4; k++) begin
      lane_we[k]    = clearing || (accept && bus.req_we && !err && strobe[k]);
      lane_wdata[k] = clearing ? 8'h00 : rep_data[8*k +: 8];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    mem_lane #(
      .DEPTH_W (DEPTH_W),
      .IDX_W   (IDX_W)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[k]),
      .widx  (lane_widx),
      .wdata (lane_wdata[k]),
      .re    (lane_re),
      .ridx  (idx),
      .rdata (lane_rdata[k])
    );
  end

  assign lane_word = {lane_rdata[3], lane_rdata[2], lane_rdata[1], lane_rdata[0]};

  // Request attributes are held so the load data can be extended as it leaves the lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      rsp_load      <= 1'b0;
      rsp_size      <= SZ_BYTE;
      rsp_off       <= 2'b00;
      rsp_uns       <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err <= err;
        rsp_load    <= !bus.req_we && !err;
        rsp_size    <= size;
        rsp_off     <= off;
        rsp_uns     <= bus.req_unsigned;
      end
    end
  end

  always_comb begin
    bus.rsp_rdata = 32'h0;
    if (bus.rsp_valid && rsp_load)
      bus.rsp_rdata = extend_load(lane_word, rsp_size, rsp_off, rsp_uns);
  end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised byte-addressable data memory for the RV32 core's load/store unit, replacing the flat word-lane memory. Requests use a valid/ready handshake, and each accepted request produces a registered one-cycle-latency response. It supports byte, half and word accesses with sign/zero extension and raises an error on misaligned or out-of-range addresses. After reset, a sweep FSM zero-fills the array before the first request is accepted.

## Interface
- ADDR_BITS, default 10: byte-address width; capacity is 2**ADDR_BITS bytes (ADDR_BITS ≥ 2).
- DEPTH_W, derived, 2**(ADDR_BITS-2): words per byte lane.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- vccd1, vssd1  inout  1  power pins, present only under USE_POWER_PINS.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  output  1  one-cycle pulse; response for the previous accepted request.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, out of range or reserved size.

## Operation
- **States:** CLEAR and READY.
- **Reset:** rst forces CLEAR with clear counter = 0. On the reset edge, rsp_valid, rsp_rdata and rsp_err are set to 0 and req_ready is 0. This also applies when reset arrives mid-clear or mid-transaction; an in-flight response is dropped.
- **CLEAR:** writes 0 to all four lanes at word index = counter, then increments the counter. After writing index DEPTH_W-1, the FSM moves to READY. req_ready = 0 throughout.
- **READY:** req_ready = 1 constantly. There is no response backpressure, so the consumer must always accept rsp_valid.
- **Accept:** a request is accepted when req_valid && req_ready.
- **Error check (combinational on the request):**
  - req_addr[31:ADDR_BITS] ≠ 0;
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0.
  - An erroring request has no memory side effect; the response carries rsp_err = 1 and rsp_rdata = 0.
- **Store:** the word index is addr[ADDR_BITS-1:2]. Lane write strobes are:
  - byte: 1 << addr[1:0];
  - half: 0011 << addr[1:0];
  - word: 1111.
  - The data is replicated onto the lanes (byte ×4, half ×2). rsp_valid = 1 with rdata = 0 and err = 0.
- **Load:** all four lanes are read at the word index. The selected byte or half is shifted by addr[1:0], then extended to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- **Lane order:** little-endian; lane k holds byte address 4·index + k.
- **Invalid inputs:** req_* values are don't-care when req_valid = 0; nothing changes state.

## Timing
- Clear takes exactly DEPTH_W cycles after rst deasserts, so req_ready first rises in cycle DEPTH_W after deassertion (256 cycles at the default).
- Load and store latency is 1: a request accepted at edge N produces rsp_valid at edge N+1, holding for one cycle unless another request is accepted.
- Throughput is one request per cycle.
- **Store then load:** a store accepted at edge N is visible to a load accepted at edge N+1 or later.
- **Same-cycle read and write:** not possible, since there is a single request port.
- **Address wrap:** none. Addresses of 2**ADDR_BITS or above error out rather than wrapping.

## Structure
- **Package mem_pkg:** size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, the state encoding ST_CLEAR/ST_READY, and the strobe-generation and load-extension functions.
- **Sub-module mem_lane:** an 8-bit, DEPTH_W-entry RAM with a synchronous write (we, widx, wdata) and a registered read. data_memory instantiates four copies, one per lane, so each lane can later be swapped for a hard macro.
- **Top level:** data_memory contains the FSM, clear counter, error check, strobe/replication logic and response registers.

## Test plan
- **Reset and clear:** ADDR_BITS = 6, release rst.
  - req_ready stays 0 for exactly 16 cycles, then rises.
  - A word load of 0x00 returns 0x00000000 with err = 0.
- **Byte store and loads:**
  - Store byte 0x80 at 0x05, then load word at 0x04: returns 0x00008000.
  - Load byte at 0x05, signed: 0xFFFFFF80. Unsigned: 0x00000080.
- **Half and word, back-to-back:**
  - Store word 0xDEADBEEF at 0x08, then immediately load half at 0x0A, signed: returns 0xFFFFDEAD.
  - rsp_valid is high on two consecutive cycles.
- **Errors:** each of the following returns err = 1 with rdata = 0, and a following word load at 0x0C still returns 0:
  - half at 0x03;
  - word at 0x0E;
  - size 11;
  - address 0x400 with ADDR_BITS = 10.
  - A store to 0x0E with size = word has no effect.
- **Reset mid-operation:**
  - Assert rst in the cycle after a load is accepted: rsp_valid is 0 after the edge.
  - Previously written data reads back as 0 after the re-clear.
